// File: rtl/uart_reg_bank.sv
// UART register bank: control/status register, TX byte buffer drained by a send sequencer,
// and an RX FIFO. Define UART_IRQ_EN to add irq_o and the IRQ_EN / TX_COMPLETE control bits.
module uart_reg_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RX_DEPTH = 4,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned RAW     = $clog2(RX_DEPTH),
  localparam int unsigned CW      = $clog2(RX_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [1:0]        reg_sel_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] entrada_i,
  output logic [DATA_W-1:0] salida_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_done_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i
`ifdef UART_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam logic [1:0] SelCtrl = 2'b00;
  localparam logic [1:0] SelTx   = 2'b01;
  localparam logic [1:0] SelRx   = 2'b10;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitDone} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           send_q, send_d;
  logic [7:0]     len_q, len_d;
  logic           rx_ovf_q, rx_ovf_d;
  logic [7:0]     tx_buf_q [DEPTH];
  logic [7:0]     tx_buf_d [DEPTH];
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [RAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;

  logic          wr_ctrl, wr_tx;
  logic          busy, addr_ok, len_ok, tx_last;
  logic          rx_full, rx_empty, rx_pop, push_ok, overflow;
  logic          send_clr, tx_fin;
  logic [AW-1:0] idx_nxt;
  logic          irq_en_rd, tx_cmpl_rd;
  logic [23:0]   ctrl_rd;

  assign wr_ctrl  = wr_i && (reg_sel_i == SelCtrl);
  assign wr_tx    = wr_i && (reg_sel_i == SelTx);
  assign busy     = (state_q != StIdle);
  assign addr_ok  = 32'(addr_i) < DEPTH;
  assign len_ok   = (len_q != 8'd0) && (32'(len_q) <= DEPTH);
  assign idx_nxt  = idx_q + AW'(1);
  assign tx_last  = (32'(idx_q) + 32'd1) == 32'(len_q);

  assign rx_full  = 32'(rx_cnt_q) == RX_DEPTH;
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = wr_i && (reg_sel_i == SelRx) && !rx_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = rx_valid_i && (!rx_full || rx_pop);
  assign overflow = rx_valid_i && rx_full && !rx_pop;

  // Send sequencer next state. tx_start/tx_data are loaded on entry to StLoad so the
  // registered pulse coincides with the StLoad cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    send_clr   = 1'b0;
    tx_fin     = 1'b0;
    case (state_q)
      StIdle: begin
        if (send_q) begin
          if (len_ok) begin
            idx_d      = '0;
            state_d    = StLoad;
            tx_start_d = 1'b1;
            tx_data_d  = tx_buf_q[0];
          end else begin
            send_clr = 1'b1;
          end
        end
      end
      StLoad: state_d = StWaitDone;
      StWaitDone: begin
        if (tx_done_i) begin
          if (tx_last) begin
            send_clr = 1'b1;
            tx_fin   = 1'b1;
            state_d  = StIdle;
          end else begin
            idx_d      = idx_nxt;
            state_d    = StLoad;
            tx_start_d = 1'b1;
            tx_data_d  = tx_buf_q[idx_nxt];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    send_d   = send_q & ~send_clr;
    len_d    = len_q;
    rx_ovf_d = rx_ovf_q;
    if (wr_ctrl && !busy) begin
      send_d = entrada_i[0];
      len_d  = entrada_i[15:8];
    end
    if (wr_ctrl && entrada_i[3]) begin
      rx_ovf_d = 1'b0;
    end
    if (overflow) begin
      rx_ovf_d = 1'b1;
    end
  end

  always_comb begin
    tx_buf_d = tx_buf_q;
    if (wr_tx && !busy && addr_ok) begin
      tx_buf_d[addr_i] = entrada_i[7:0];
    end
  end

  always_comb begin
    rx_mem_d = rx_mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rx_cnt_d = rx_cnt_q;
    if (push_ok) begin
      rx_mem_d[wr_ptr_q] = rx_data_i;
      wr_ptr_d           = wr_ptr_q + RAW'(1);
    end
    if (rx_pop) begin
      rd_ptr_d = rd_ptr_q + RAW'(1);
    end
    if (push_ok && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CW'(1);
    end else if (!push_ok && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      send_q     <= 1'b0;
      len_q      <= 8'h00;
      rx_ovf_q   <= 1'b0;
      tx_buf_q   <= '{default: '0};
      rx_mem_q   <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      send_q     <= send_d;
      len_q      <= len_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_buf_q   <= tx_buf_d;
      rx_mem_q   <= rx_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

`ifdef UART_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic tx_cmpl_q, tx_cmpl_d;
  logic irq_q, irq_d;

  // IRQ_EN stays writable while busy; a completion in the same cycle as its W1C wins.
  always_comb begin
    irq_en_d  = irq_en_q;
    tx_cmpl_d = tx_cmpl_q;
    if (wr_ctrl) begin
      irq_en_d = entrada_i[4];
      if (entrada_i[5]) begin
        tx_cmpl_d = 1'b0;
      end
    end
    if (tx_fin) begin
      tx_cmpl_d = 1'b1;
    end
    irq_d = irq_en_q & (~rx_empty | rx_ovf_q | tx_cmpl_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q  <= 1'b0;
      tx_cmpl_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      tx_cmpl_q <= tx_cmpl_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o      = irq_q;
  assign irq_en_rd  = irq_en_q;
  assign tx_cmpl_rd = tx_cmpl_q;
`else
  logic unused_tx_fin;
  assign unused_tx_fin = tx_fin;
  assign irq_en_rd     = 1'b0;
  assign tx_cmpl_rd    = 1'b0;
`endif

  assign ctrl_rd = {8'(rx_cnt_q), len_q, 2'b00, tx_cmpl_rd, irq_en_rd,
                    rx_ovf_q, ~rx_empty, busy, send_q};

  always_comb begin
    salida_o = '0;
    case (reg_sel_i)
      SelCtrl: salida_o = DATA_W'(ctrl_rd);
      SelTx:   if (addr_ok) salida_o = DATA_W'(tx_buf_q[addr_i]);
      SelRx:   if (!rx_empty) salida_o = DATA_W'(rx_mem_q[rd_ptr_q]);
      default: salida_o = '0;
    endcase
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

  logic unused_entrada;
  assign unused_entrada = ^entrada_i[DATA_W-1:16];

endmodule

// File: tb/tb_uart_reg_bank.sv
// Self-checking bench for uart_reg_bank: vector table, hand-written TX/RX corner sequences
// and a randomized RX FIFO run against a queue-based reference model.
module tb_uart_reg_bank;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [1:0]  reg_sel = 2'b00;
  logic [1:0]  addr = 2'b00;
  logic [31:0] entrada = '0;
  logic [31:0] salida;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  uart_reg_bank #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (wr),
    .reg_sel_i (reg_sel),
    .addr_i    (addr),
    .entrada_i (entrada),
    .salida_o  (salida),
    .tx_start_o(tx_start),
    .tx_data_o (tx_data),
    .tx_done_i (tx_done),
    .rx_valid_i(rx_valid),
    .rx_data_i (rx_data)
`ifdef UART_IRQ_EN
    ,
    .irq_o     (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; reg_sel = sel; addr = a; entrada = d;
    step();
    wr = 1'b0; entrada = '0;
  endtask

  task automatic rd_reg(input logic [1:0] sel, input logic [1:0] a, output logic [31:0] d);
    reg_sel = sel; addr = a;
    #1;
    d = salida;
  endtask

  // Kick a send of n bytes and walk it; meddle tries a buffer write and a LEN=1 control
  // write while busy, both of which must be ignored.
  task automatic run_tx(input int n, input logic [23:0] exp_bytes, input bit meddle);
    logic [31:0] d;
    int cyc;
    wr_reg(2'b00, 2'd0, (32'(n) << 8) | 32'h1);
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (tx_start !== 1'b1 && cyc < 20) begin
        step();
        cyc++;
      end
      check($sformatf("tx%0d_latency", i), 32'(cyc), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("tx%0d_data", i), 32'(tx_data), 32'(exp_bytes[8*i +: 8]));
      step();
      check($sformatf("tx%0d_pulse_width", i), 32'(tx_start), 32'd0);
      if (meddle && i == 0) begin
        wr_reg(2'b01, 2'd1, 32'h0000_0099);
        wr_reg(2'b00, 2'd0, 32'h0000_0101);
      end
      rd_reg(2'b00, 2'd0, d);
      check($sformatf("tx%0d_busy_ctrl", i), d, (32'(n) << 8) | 32'h3);
      step();
      check($sformatf("tx%0d_no_restart", i), 32'(tx_start), 32'd0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    rd_reg(2'b00, 2'd0, d);
    check("tx_end_ctrl", d, 32'(n) << 8);
    check("tx_end_no_start", 32'(tx_start), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  mq[$];
    bit          movf;
    bit          seen;
    int          cyc;

    vecs[0] = '{2'b01, 2'd0, 32'hFFFF_FF41, 32'h0000_0041};
    vecs[1] = '{2'b01, 2'd1, 32'h0000_0142, 32'h0000_0042};
    vecs[2] = '{2'b01, 2'd2, 32'h1234_5643, 32'h0000_0043};
    vecs[3] = '{2'b01, 2'd3, 32'h0000_00EE, 32'h0000_00EE};
    vecs[4] = '{2'b11, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{2'b00, 2'd0, 32'h0000_0500, 32'h0000_0500};
    vecs[6] = '{2'b00, 2'd0, 32'hFFFF_00C0, 32'h0000_0000};

    // Reset state
    step(); step();
    rst = 1'b0;
    rd_reg(2'b00, 2'd0, d); check("rst_ctrl", d, 32'h0);
    rd_reg(2'b10, 2'd0, d); check("rst_rx", d, 32'h0);
    rd_reg(2'b01, 2'd2, d); check("rst_buf", d, 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    for (int i = 0; i < 7; i++) begin
      wr_reg(vecs[i].sel, vecs[i].addr, vecs[i].wdata);
      rd_reg(vecs[i].sel, vecs[i].addr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    run_tx(3, 24'h434241, 1'b0);

    // SEND with LEN out of range
    wr_reg(2'b00, 2'd0, 32'h0000_0001);
    rd_reg(2'b00, 2'd0, d); check("len0_send_set", d, 32'h0000_0001);
    step();
    rd_reg(2'b00, 2'd0, d); check("len0_send_clr", d, 32'h0);
    wr_reg(2'b00, 2'd0, 32'h0000_0501);
    step();
    rd_reg(2'b00, 2'd0, d); check("len5_send_clr", d, 32'h0000_0500);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_start) seen = 1'b1;
      step();
    end
    check("bad_len_no_start", 32'(seen), 32'd0);

    run_tx(2, 24'h004241, 1'b1);
    rd_reg(2'b01, 2'd1, d); check("busy_buf_unchanged", d, 32'h42);

    // RX overflow and simultaneous push/pop
    wr_reg(2'b00, 2'd0, 32'h0);
    for (int i = 0; i <= RX_DEPTH; i++) begin
      rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    rd_reg(2'b00, 2'd0, d); check("ovf_ctrl", d, 32'h0004_000C);
    rd_reg(2'b10, 2'd0, d); check("ovf_head", d, 32'h10);
    rx_valid = 1'b1; rx_data = 8'h20;
    wr_reg(2'b10, 2'd0, 32'hFFFF_FFFF);
    rx_valid = 1'b0;
    rd_reg(2'b00, 2'd0, d); check("full_pushpop_ctrl", d, 32'h0004_000C);
    rd_reg(2'b10, 2'd0, d); check("full_pushpop_head", d, 32'h11);
    wr_reg(2'b00, 2'd0, 32'h0000_0008);
    rd_reg(2'b00, 2'd0, d); check("ovf_w1c", d, 32'h0004_0004);
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'b10, 2'd0, d);
      check($sformatf("drain%0d", i), d, (i == 3) ? 32'h20 : 32'h11 + 32'(i));
      wr_reg(2'b10, 2'd0, 32'h0);
    end
    wr_reg(2'b10, 2'd0, 32'h0);
    rd_reg(2'b00, 2'd0, d); check("empty_pop_ctrl", d, 32'h0);
    rx_valid = 1'b1; rx_data = 8'h5A;
    wr_reg(2'b10, 2'd0, 32'h0);
    rx_valid = 1'b0;
    rd_reg(2'b00, 2'd0, d); check("empty_pushpop_ctrl", d, 32'h0001_0004);
    rd_reg(2'b10, 2'd0, d); check("empty_pushpop_head", d, 32'h5A);

    // Reset in the middle of a send
    wr_reg(2'b00, 2'd0, 32'h0000_0301);
    cyc = 0;
    while (tx_start !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("midrst_first_start", 32'(cyc), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_reg(2'b00, 2'd0, d); check("midrst_ctrl", d, 32'h0);
    rd_reg(2'b10, 2'd0, d); check("midrst_rx", d, 32'h0);
    rd_reg(2'b01, 2'd0, d); check("midrst_buf", d, 32'h0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tx_start) seen = 1'b1;
      step();
    end
    check("midrst_no_start", 32'(seen), 32'd0);

    // Randomized RX traffic against a queue model
    mq.delete();
    movf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      int  op;
      bit  push, pop, clr, did_pop;
      logic [7:0]  b;
      logic [31:0] exp;
      op   = int'($urandom_range(0, 9));
      push = ($urandom_range(0, 1) == 1);
      b    = 8'($urandom);
      pop  = (op < 3);
      clr  = (op == 3);
      rx_valid = push; rx_data = b;
      wr = pop || clr;
      entrada = clr ? 32'h8 : 32'h0;
      if (pop) reg_sel = 2'b10;
      else if (clr) reg_sel = 2'b00;
      else reg_sel = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      #1;
      if (reg_sel == 2'b10) exp = (mq.size() != 0) ? 32'(mq[0]) : 32'h0;
      else exp = (32'(mq.size()) << 16) | (32'(movf) << 3) | ((mq.size() != 0) ? 32'h4 : 32'h0);
      check($sformatf("rand%0d_sel%0d", c, reg_sel), salida, exp);
      step();
      did_pop = pop && (mq.size() != 0);
      if (clr) movf = 1'b0;
      if (push) begin
        if (mq.size() < RX_DEPTH || did_pop) mq.push_back(b);
        else movf = 1'b1;
      end
      if (did_pop) void'(mq.pop_front());
    end
    wr = 1'b0; rx_valid = 1'b0;
    rd_reg(2'b00, 2'd0, d);
    check("rand_final_ctrl", d,
          (32'(mq.size()) << 16) | (32'(movf) << 3) | ((mq.size() != 0) ? 32'h4 : 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
